sobol_rng_dim1: RTL and testbench
=================================

SOBOL_RNG_DIM1 -- requirements
Module: sobol_rng_dim1

Interface
REQ-001 SHALL have parameter RWID, default 8, meaning output/sequence width in bits; legal range 2..32.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-high (asserted when 1, sampled on the rising clk edge), despite the _n suffix.
REQ-004 SHALL have port enable, input, 1 bit: advances the sequence by one element per clock when 1.
REQ-005 SHALL have port sobolSeq, output, RWID bits: current element of the dimension-1 Sobol sequence, driven directly from a register.

Function
REQ-006 SHALL hold an RWID-bit index counter idx and an RWID-bit output register sobolSeq.
REQ-007 SHALL use direction vectors v[k] = 1 << (RWID-1-k) for k = 0..RWID-1, held as constants.
REQ-008 SHALL, on a rising edge with enable=1 and reset deasserted, compute c = index of the least-significant 0 bit of idx, then set sobolSeq <= sobolSeq XOR v[c] and idx <= idx+1 (Gray-code Antonov-Saleev update).
REQ-009 SHALL find c with a priority encoder over the inverted idx; latency from enable to updated output is exactly one clock.
REQ-010 SHALL, when idx is all ones (no 0 bit), set sobolSeq <= 0 and idx <= 0 (wrap); the period is 2^RWID elements.
REQ-011 SHALL hold idx and sobolSeq unchanged on any edge with enable=0.
REQ-012 SHALL always satisfy sobolSeq == bit-reverse(idx XOR (idx>>1)); each period emits every RWID-bit value exactly once.
REQ-013 SHALL have no combinational path from any input to sobolSeq.

Reset
REQ-014 SHALL, on any rising edge with rst_n=1, set idx=0 and sobolSeq=0, overriding enable.
REQ-015 SHALL, on reset asserted mid-sequence, discard all progress; the first enabled edge after release produces 2^(RWID-1).
REQ-016 SHALL present sobolSeq=0 in the cycle after reset release until the first enabled edge.

Verification
REQ-017 Reset then enable=1 for 16 clocks, RWID=8 -> sobolSeq sequence 0,128,192,64,96,224,160,32,48,176,240,112,80,208,144,16.
REQ-018 Run 256 enabled clocks from reset -> all 256 values appear exactly once; element 255 = 1; clock 256 returns 0 and element 257 = 128.
REQ-019 After 5 enabled clocks (output 224), drop enable for 3 clocks -> output stays 224; re-enable -> 160 then 32.
REQ-020 Assert reset for one clock while output is 112 with enable=1 -> output 0 next cycle; following enabled clocks give 128,192.
REQ-021 Random enable toggling over 1000 clocks -> scoreboard check sobolSeq == bit-reverse(gray(number of enabled edges since reset mod 256)) every cycle.
REQ-022 Re-run REQ-017 with RWID=4 -> 0,8,12,4,6,14,10,2,3,11,15,7,5,13,9,1, then 0.

Source files
------------

// File: rtl/sobol_rng_dim1.sv
// Dimension-1 Sobol sequence generator using the Gray-code (Antonov-Saleev) update.
// One new element per enabled clock, output registered, period 2^RWID.
module sobol_rng_dim1 #(
  parameter int RWID = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  output logic [RWID-1:0] sobolSeq
);

  localparam logic [RWID-1:0] ONE = {{(RWID-1){1'b0}}, 1'b1};

  logic [RWID-1:0] idx_q, idx_d;
  logic [RWID-1:0] seq_q, seq_d;
  logic [RWID-1:0] dir_v;
  logic            all_ones;

  // Priority encoder over ~idx: the lowest zero bit k selects v[k] = 1 << (RWID-1-k).
  always_comb begin
    dir_v = '0;
    for (int k = RWID - 1; k >= 0; k--) begin
      if (!idx_q[k]) begin
        dir_v = ONE << (RWID - 1 - k);
      end
    end
  end

  assign all_ones = &idx_q;

  always_comb begin
    idx_d = idx_q;
    seq_d = seq_q;
    if (enable) begin
      if (all_ones) begin
        idx_d = '0;
        seq_d = '0;
      end else begin
        idx_d = idx_q + ONE;
        seq_d = seq_q ^ dir_v;
      end
    end
  end

  // Reset is active-high even though the port keeps its historical _n name.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      idx_q <= '0;
      seq_q <= '0;
    end else begin
      idx_q <= idx_d;
      seq_q <= seq_d;
    end
  end

  assign sobolSeq = seq_q;

endmodule

// File: tb/tb_sobol_rng_dim1.sv
// Bench for sobol_rng_dim1: 8-bit and 4-bit instances checked against a count-based
// model (bit-reverse of Gray code of enabled edges since reset) plus fixed tables.
module tb_sobol_rng_dim1;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] seq8;
  logic [3:0] seq4;

  int checks;
  int failures;
  int n_en;

  sobol_rng_dim1 #(.RWID(8)) dut8 (
    .clk      (clk),
    .rst_n    (rst),
    .enable   (en),
    .sobolSeq (seq8)
  );

  sobol_rng_dim1 #(.RWID(4)) dut4 (
    .clk      (clk),
    .rst_n    (rst),
    .enable   (en),
    .sobolSeq (seq4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sobol_ref(input int n, input int w);
    int m;
    int g;
    int r;
    m = n % (1 << w);
    g = m ^ (m >> 1);
    r = 0;
    for (int b = 0; b < w; b++) begin
      if (((g >> b) & 1) != 0) r = r | (1 << (w - 1 - b));
    end
    return r;
  endfunction

  // One clock with the given inputs; outputs are sampled 1 time unit after the edge
  // and compared with the model for both widths.
  task automatic step(input logic e, input logic r);
    en  = e;
    rst = r;
    @(posedge clk);
    #1;
    if (r) n_en = 0;
    else if (e) n_en++;
    check_val("model8", int'(seq8), sobol_ref(n_en, 8));
    check_val("model4", int'(seq4), sobol_ref(n_en, 4));
  endtask

  int exp8 [16];
  int exp4 [16];
  bit seen [256];
  int distinct;

  initial begin
    checks   = 0;
    failures = 0;
    n_en     = 0;
    en       = 1'b0;
    rst      = 1'b1;
    exp8 = '{0, 128, 192, 64, 96, 224, 160, 32, 48, 176, 240, 112, 80, 208, 144, 16};
    exp4 = '{0, 8, 12, 4, 6, 14, 10, 2, 3, 11, 15, 7, 5, 13, 9, 1};

    // Reset, then idle after release: output stays zero.
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    check_val("reset8", int'(seq8), 0);
    check_val("reset4", int'(seq4), 0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check_val("idle_after_reset", int'(seq8), 0);

    // Full period from reset, with the fixed 16-element tables for both widths.
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    seen[seq8] = 1'b1;
    check_val("elem0_8", int'(seq8), exp8[0]);
    check_val("elem0_4", int'(seq4), exp4[0]);
    for (int i = 1; i < 256; i++) begin
      step(1'b1, 1'b0);
      seen[seq8] = 1'b1;
      if (i < 16) begin
        check_val($sformatf("tab8_%0d", i), int'(seq8), exp8[i]);
        check_val($sformatf("tab4_%0d", i), int'(seq4), exp4[i]);
      end
      if (i == 16) check_val("wrap4", int'(seq4), 0);
    end
    check_val("elem255", int'(seq8), 1);
    distinct = 0;
    for (int i = 0; i < 256; i++) if (seen[i]) distinct++;
    check_val("distinct", distinct, 256);
    step(1'b1, 1'b0);
    check_val("wrap8", int'(seq8), 0);
    step(1'b1, 1'b0);
    check_val("after_wrap8", int'(seq8), 128);

    // Hold while enable is low.
    step(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    check_val("five_en", int'(seq8), 224);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0);
      check_val("hold", int'(seq8), 224);
    end
    step(1'b1, 1'b0);
    check_val("resume1", int'(seq8), 160);
    step(1'b1, 1'b0);
    check_val("resume2", int'(seq8), 32);

    // Reset mid-sequence with enable held high.
    step(1'b0, 1'b1);
    for (int i = 0; i < 11; i++) step(1'b1, 1'b0);
    check_val("pre_reset", int'(seq8), 112);
    step(1'b1, 1'b1);
    check_val("mid_reset", int'(seq8), 0);
    step(1'b1, 1'b0);
    check_val("post_reset1", int'(seq8), 128);
    step(1'b1, 1'b0);
    check_val("post_reset2", int'(seq8), 192);

    // Random enable toggling; the model check in step runs every cycle.
    step(1'b0, 1'b1);
    for (int i = 0; i < 1000; i++) begin
      step(logic'($urandom_range(1, 0)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
